// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Front-end hazard controller for a classic 5-stage in-order pipeline.
//   It stalls IF/ID on read-after-write hazards, flushes the front end on a
//   taken branch, and freezes the front end while a multi-cycle mul/div op
//   occupies EX. It also keeps a saturating count of frozen-front-end cycles.
//
// Configuration macro:
//   HAZ_FORWARD_EN - when defined, the datapath has full forwarding, so only a
//                    load in EX feeding the ID instruction (load-use) stalls.
//                    When undefined, any pending EX or MEM writer of a source
//                    register stalls ID.
//
// Parameters:
//   MULDIV_CYCLES  - cycles a mul/div op occupies EX (2..63, default 32).
//
// Ports:
//   clk                 in   1  clock, rising edge
//   reset               in   1  synchronous active-high reset
//   rs_id_i, rt_id_i    in   5  source registers of the ID instruction
//   uses_rs_id_i        in   1  ID instruction reads rs
//   uses_rt_id_i        in   1  ID instruction reads rt
//   reg_wr_ex_i         in   1  EX instruction writes a register
//   mem_to_reg_ex_i     in   1  EX instruction is a load
//   rd_ex_i             in   5  EX destination register
//   reg_wr_mem_i        in   1  MEM instruction writes a register
//   rd_mem_i            in   5  MEM destination register
//   branch_taken_ex_i   in   1  branch/jump in EX resolved taken
//   muldiv_start_ex_i   in   1  mul/div instruction present in EX
//   stall_clr_i         in   1  clear the stall counter
//   pc_en_o             out  1  PC update enable
//   if_id_en_o          out  1  IF/ID capture enable
//   if_id_flush_o       out  1  IF/ID loads a NOP
//   id_ex_flush_o       out  1  ID/EX loads a bubble
//   ex_mem_bubble_o     out  1  EX/MEM loads a bubble
//   muldiv_busy_o       out  1  mul/div in progress
//   muldiv_done_o       out  1  pulse on the last mul/div cycle
//   stall_cycles_o      out 16  saturating frozen-front-end cycle count
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_id_i,
    input  logic [4:0]  rt_id_i,
    input  logic        uses_rs_id_i,
    input  logic        uses_rt_id_i,
    input  logic        reg_wr_ex_i,
    input  logic        mem_to_reg_ex_i,
    input  logic [4:0]  rd_ex_i,
    input  logic        reg_wr_mem_i,
    input  logic [4:0]  rd_mem_i,
    input  logic        branch_taken_ex_i,
    input  logic        muldiv_start_ex_i,
    input  logic        stall_clr_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_bubble_o,
    output logic        muldiv_busy_o,
    output logic        muldiv_done_o,
    output logic [15:0] stall_cycles_o
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [5:0] MD_LOAD = 6'(MULDIV_CYCLES - 1);

    state_t      r_state;
    logic [5:0]  r_md_cnt;
    logic [15:0] r_stall_cnt;

    logic        w_rs_ex_match;
    logic        w_rt_ex_match;
    logic        w_rs_mem_match;
    logic        w_rt_mem_match;
    logic        w_hazard;
    logic        w_pc_en;

    // Source/destination comparisons. Register 0 is hard-wired to zero, so a
    // "write" to it can never create a dependency.
    assign w_rs_ex_match  = uses_rs_id_i && (rs_id_i != 5'd0) && (rs_id_i == rd_ex_i);
    assign w_rt_ex_match  = uses_rt_id_i && (rt_id_i != 5'd0) && (rt_id_i == rd_ex_i);
    assign w_rs_mem_match = uses_rs_id_i && (rs_id_i != 5'd0) && (rs_id_i == rd_mem_i);
    assign w_rt_mem_match = uses_rt_id_i && (rt_id_i != 5'd0) && (rt_id_i == rd_mem_i);

`ifdef HAZ_FORWARD_EN
    // With forwarding, only a load result is unavailable in time for the
    // dependent instruction; MEM-stage results are forwarded.
    logic w_unused_mem;
    assign w_unused_mem = ^{reg_wr_mem_i, w_rs_mem_match, w_rt_mem_match};
    assign w_hazard = reg_wr_ex_i && mem_to_reg_ex_i && (w_rs_ex_match || w_rt_ex_match);
`else
    // Without forwarding, any writer still in EX or MEM blocks the read. The
    // register file writes before it reads, so WB needs no check.
    logic w_unused_load;
    assign w_unused_load = mem_to_reg_ex_i;
    assign w_hazard = (reg_wr_ex_i  && (w_rs_ex_match  || w_rt_ex_match)) ||
                      (reg_wr_mem_i && (w_rs_mem_match || w_rt_mem_match));
`endif

    // Pipeline control decode. Priority: reset, mul/div freeze (EX is owned
    // by the mul/div so a branch there cannot be acted on), taken branch,
    // then RAW hazard. During mul/div the ID/EX register is held by its own
    // enable path, so no flush is issued there; EX/MEM gets bubbles instead.
    always_comb begin
        w_pc_en         = 1'b1;
        if_id_en_o      = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_flush_o   = 1'b0;
        ex_mem_bubble_o = 1'b0;
        muldiv_busy_o   = 1'b0;
        muldiv_done_o   = 1'b0;
        if (reset) begin
            w_pc_en         = 1'b0;
            if_id_en_o      = 1'b0;
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            ex_mem_bubble_o = 1'b1;
        end else if (r_state == MD_BUSY) begin
            w_pc_en         = 1'b0;
            if_id_en_o      = 1'b0;
            ex_mem_bubble_o = 1'b1;
            muldiv_busy_o   = 1'b1;
            muldiv_done_o   = (r_md_cnt == 6'd0);
        end else if (branch_taken_ex_i) begin
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
        end else if (w_hazard) begin
            w_pc_en         = 1'b0;
            if_id_en_o      = 1'b0;
            id_ex_flush_o   = 1'b1;
        end
    end

    assign pc_en_o = w_pc_en;

    // Mul/div occupancy FSM. The countdown is loaded with MULDIV_CYCLES-1 so
    // that MD_BUSY lasts exactly MULDIV_CYCLES cycles, ending on md_cnt==0.
    // A taken branch in the same cycle squashes the mul/div, so no entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_md_cnt <= 6'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (muldiv_start_ex_i && !branch_taken_ex_i) begin
                        r_state  <= MD_BUSY;
                        r_md_cnt <= MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (r_md_cnt == 6'd0) begin
                        r_state <= RUN;
                    end else begin
                        r_md_cnt <= r_md_cnt - 6'd1;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_md_cnt <= 6'd0;
                end
            endcase
        end
    end

    // Frozen-front-end cycle counter. Clear wins over increment, and the
    // count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (stall_clr_i) begin
            r_stall_cnt <= 16'd0;
        end else if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl (MULDIV_CYCLES=4). Combinational
// decode is checked from a vector table; multi-cycle behaviour (stall
// lengths, mul/div occupancy, reset abort, counter saturation) is checked by
// hand-written sequences. Expectations follow HAZ_FORWARD_EN when defined.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

`ifdef HAZ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [4:0]  rsId, rtId, rdEx, rdMem;
    logic        usesRs, usesRt, wrEx, m2rEx, wrMem, brTaken, mdStart, stallClr;
    logic        pcEn, ifIdEn, ifIdFlush, idExFlush, exMemBubble, mdBusy, mdDone;
    logic [15:0] stallCycles;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .rs_id_i           (rsId),
        .rt_id_i           (rtId),
        .uses_rs_id_i      (usesRs),
        .uses_rt_id_i      (usesRt),
        .reg_wr_ex_i       (wrEx),
        .mem_to_reg_ex_i   (m2rEx),
        .rd_ex_i           (rdEx),
        .reg_wr_mem_i      (wrMem),
        .rd_mem_i          (rdMem),
        .branch_taken_ex_i (brTaken),
        .muldiv_start_ex_i (mdStart),
        .stall_clr_i       (stallClr),
        .pc_en_o           (pcEn),
        .if_id_en_o        (ifIdEn),
        .if_id_flush_o     (ifIdFlush),
        .id_ex_flush_o     (idExFlush),
        .ex_mem_bubble_o   (exMemBubble),
        .muldiv_busy_o     (mdBusy),
        .muldiv_done_o     (mdDone),
        .stall_cycles_o    (stallCycles)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usesRs;
        logic       usesRt;
        logic       wrEx;
        logic       m2rEx;
        logic [4:0] rdEx;
        logic       wrMem;
        logic [4:0] rdMem;
        logic       br;
        logic       expPcEn;
        logic       expIfIdEn;
        logic       expIfIdFlush;
        logic       expIdExFlush;
        logic       expExMemBubble;
    } vec_t;

    vec_t vecs[13];

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        rsId = 5'd0; rtId = 5'd0; usesRs = 1'b0; usesRt = 1'b0;
        wrEx = 1'b0; m2rEx = 1'b0; rdEx = 5'd0;
        wrMem = 1'b0; rdMem = 5'd0;
        brTaken = 1'b0; mdStart = 1'b0; stallClr = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        rsId = v.rs; rtId = v.rt; usesRs = v.usesRs; usesRt = v.usesRt;
        wrEx = v.wrEx; m2rEx = v.m2rEx; rdEx = v.rdEx;
        wrMem = v.wrMem; rdMem = v.rdMem; brTaken = v.br;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearCounter();
        stallClr = 1'b1;
        tick();
        stallClr = 1'b0;
    endtask

    initial begin
        // Vector table: name, rs, rt, usesRs, usesRt, wrEx, m2rEx, rdEx,
        // wrMem, rdMem, br, expected pcEn, ifIdEn, ifIdFlush, idExFlush, exMemBubble.
        vecs[0]  = '{"idle",         5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 5'd0,  0, 1,   1,   0, 0,    0};
        vecs[1]  = '{"alu_ex_rs",    5'd3,  5'd0,  1, 0, 1, 0, 5'd3,  0, 5'd0,  0, FWD, FWD, 0, !FWD, 0};
        vecs[2]  = '{"load_ex_rs",   5'd5,  5'd0,  1, 0, 1, 1, 5'd5,  0, 5'd0,  0, 0,   0,   0, 1,    0};
        vecs[3]  = '{"load_unused",  5'd5,  5'd0,  0, 0, 1, 1, 5'd5,  0, 5'd0,  0, 1,   1,   0, 0,    0};
        vecs[4]  = '{"load_ex_rt",   5'd0,  5'd9,  0, 1, 1, 1, 5'd9,  0, 5'd0,  0, 0,   0,   0, 1,    0};
        vecs[5]  = '{"load_r0",      5'd0,  5'd0,  1, 1, 1, 1, 5'd0,  0, 5'd0,  0, 1,   1,   0, 0,    0};
        vecs[6]  = '{"mem_rt",       5'd0,  5'd12, 0, 1, 0, 0, 5'd0,  1, 5'd12, 0, FWD, FWD, 0, !FWD, 0};
        vecs[7]  = '{"mem_r0",       5'd0,  5'd0,  1, 0, 0, 0, 5'd0,  1, 5'd0,  0, 1,   1,   0, 0,    0};
        vecs[8]  = '{"load_no_wr",   5'd5,  5'd0,  1, 0, 0, 1, 5'd5,  0, 5'd0,  0, 1,   1,   0, 0,    0};
        vecs[9]  = '{"load_br",      5'd5,  5'd0,  1, 0, 1, 1, 5'd5,  0, 5'd0,  1, 1,   1,   1, 1,    0};
        vecs[10] = '{"br_only",      5'd0,  5'd0,  0, 0, 0, 0, 5'd0,  0, 5'd0,  1, 1,   1,   1, 1,    0};
        vecs[11] = '{"no_match",     5'd5,  5'd7,  1, 1, 1, 1, 5'd6,  1, 5'd8,  0, 1,   1,   0, 0,    0};
        vecs[12] = '{"mem_no_wr",    5'd4,  5'd0,  1, 0, 0, 0, 5'd0,  0, 5'd4,  0, 1,   1,   0, 0,    0};

        setIdle();

        // Reset behaviour.
        reset = 1'b1;
        tick();
        checkOutput("rst_pc_en",       {15'd0, pcEn},        16'd0);
        checkOutput("rst_if_id_en",    {15'd0, ifIdEn},      16'd0);
        checkOutput("rst_if_id_flush", {15'd0, ifIdFlush},   16'd1);
        checkOutput("rst_id_ex_flush", {15'd0, idExFlush},   16'd1);
        checkOutput("rst_bubble",      {15'd0, exMemBubble}, 16'd1);
        checkOutput("rst_busy",        {15'd0, mdBusy},      16'd0);
        checkOutput("rst_done",        {15'd0, mdDone},      16'd0);
        checkOutput("rst_stall_cnt",   stallCycles,          16'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_pc_en",  {15'd0, pcEn},        16'd1);

        // Table-driven combinational decode in RUN.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, "_pc_en"},       {15'd0, pcEn},        {15'd0, vecs[i].expPcEn});
            checkOutput({vecs[i].name, "_if_id_en"},    {15'd0, ifIdEn},      {15'd0, vecs[i].expIfIdEn});
            checkOutput({vecs[i].name, "_if_id_flush"}, {15'd0, ifIdFlush},   {15'd0, vecs[i].expIfIdFlush});
            checkOutput({vecs[i].name, "_id_ex_flush"}, {15'd0, idExFlush},   {15'd0, vecs[i].expIdExFlush});
            checkOutput({vecs[i].name, "_bubble"},      {15'd0, exMemBubble}, {15'd0, vecs[i].expExMemBubble});
            checkOutput({vecs[i].name, "_busy"},        {15'd0, mdBusy},      16'd0);
            tick();
        end
        setIdle();
        clearCounter();
        checkOutput("clr_counter", stallCycles, 16'd0);

        // Load-use: one stall cycle, counter becomes 1.
        wrEx = 1'b1; m2rEx = 1'b1; rdEx = 5'd5; rsId = 5'd5; usesRs = 1'b1;
        #1;
        checkOutput("lu_pc_en",       {15'd0, pcEn},      16'd0);
        checkOutput("lu_id_ex_flush", {15'd0, idExFlush}, 16'd1);
        tick();
        setIdle();
        #1;
        checkOutput("lu_resume_pc_en", {15'd0, pcEn}, 16'd1);
        checkOutput("lu_stall_cnt",    stallCycles,   16'd1);
        tick();
        checkOutput("lu_stall_cnt_hold", stallCycles, 16'd1);
        clearCounter();

        // ALU writer x7 moves EX -> MEM while ID reads rt=7.
        wrEx = 1'b1; rdEx = 5'd7; rtId = 5'd7; usesRt = 1'b1;
        #1;
        checkOutput("alu_ex_stage_pc_en", {15'd0, pcEn}, {15'd0, FWD});
        tick();
        wrEx = 1'b0; rdEx = 5'd0; wrMem = 1'b1; rdMem = 5'd7;
        #1;
        checkOutput("alu_mem_stage_pc_en", {15'd0, pcEn}, {15'd0, FWD});
        tick();
        wrMem = 1'b0; rdMem = 5'd0;
        #1;
        checkOutput("alu_resume_pc_en", {15'd0, pcEn}, 16'd1);
        checkOutput("alu_stall_cnt",    stallCycles,   FWD ? 16'd0 : 16'd2);
        setIdle();
        clearCounter();

        // Branch beats load-use and squashes a mul/div start in EX.
        wrEx = 1'b1; m2rEx = 1'b1; rdEx = 5'd5; rsId = 5'd5; usesRs = 1'b1;
        brTaken = 1'b1; mdStart = 1'b1;
        #1;
        checkOutput("brlu_pc_en",       {15'd0, pcEn},      16'd1);
        checkOutput("brlu_if_id_flush", {15'd0, ifIdFlush}, 16'd1);
        checkOutput("brlu_id_ex_flush", {15'd0, idExFlush}, 16'd1);
        tick();
        setIdle();
        #1;
        checkOutput("brlu_no_busy",   {15'd0, mdBusy}, 16'd0);
        checkOutput("brlu_stall_cnt", stallCycles,     16'd0);

        // Mul/div: 4 busy cycles, done on the 4th; branch/start ignored inside.
        mdStart = 1'b1;
        #1;
        checkOutput("md_start_pc_en", {15'd0, pcEn}, 16'd1);
        tick();
        mdStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                brTaken = 1'b1;
                mdStart = 1'b1;
            end
            #1;
            checkOutput($sformatf("md_busy_%0d", i),        {15'd0, mdBusy},      16'd1);
            checkOutput($sformatf("md_done_%0d", i),        {15'd0, mdDone},      (i == 3) ? 16'd1 : 16'd0);
            checkOutput($sformatf("md_pc_en_%0d", i),       {15'd0, pcEn},        16'd0);
            checkOutput($sformatf("md_if_id_en_%0d", i),    {15'd0, ifIdEn},      16'd0);
            checkOutput($sformatf("md_if_id_flush_%0d", i), {15'd0, ifIdFlush},   16'd0);
            checkOutput($sformatf("md_id_ex_flush_%0d", i), {15'd0, idExFlush},   16'd0);
            checkOutput($sformatf("md_bubble_%0d", i),      {15'd0, exMemBubble}, 16'd1);
            tick();
            brTaken = 1'b0;
            mdStart = 1'b0;
        end
        #1;
        checkOutput("md_after_busy",  {15'd0, mdBusy}, 16'd0);
        checkOutput("md_after_done",  {15'd0, mdDone}, 16'd0);
        checkOutput("md_after_pc_en", {15'd0, pcEn},   16'd1);
        checkOutput("md_stall_cnt",   stallCycles,     16'd4);

        // Reset in the 2nd busy cycle aborts with no done pulse.
        mdStart = 1'b1;
        tick();
        mdStart = 1'b0;
        #1;
        checkOutput("abort_busy_1", {15'd0, mdBusy}, 16'd1);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("abort_rst_busy",  {15'd0, mdBusy},      16'd0);
        checkOutput("abort_rst_done",  {15'd0, mdDone},      16'd0);
        checkOutput("abort_rst_flush", {15'd0, ifIdFlush},   16'd1);
        checkOutput("abort_rst_bub",   {15'd0, exMemBubble}, 16'd1);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("abort_run_busy", {15'd0, mdBusy}, 16'd0);
        checkOutput("abort_run_pc",   {15'd0, pcEn},   16'd1);
        checkOutput("abort_cnt",      stallCycles,     16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("abort_no_done_%0d", i), {15'd0, mdDone | mdBusy}, 16'd0);
        end

        // Saturation: 65540 stall cycles, then clear beats a concurrent stall.
        wrEx = 1'b1; m2rEx = 1'b1; rdEx = 5'd5; rsId = 5'd5; usesRs = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        checkOutput("sat_fffe", stallCycles, 16'hFFFE);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("sat_ffff", stallCycles, 16'hFFFF);
        stallClr = 1'b1;
        #1;
        checkOutput("sat_clr_pc_en", {15'd0, pcEn}, 16'd0);
        tick();
        stallClr = 1'b0;
        checkOutput("sat_clr_zero", stallCycles, 16'd0);
        tick();
        checkOutput("sat_after_clr", stallCycles, 16'd1);
        setIdle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter MULDIV_CYCLES, default 32 (range 2..63), the number of cycles a mul/div op occupies EX.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- rs_id_i / rt_id_i, in, 5 each: source registers of the instruction in ID.
- uses_rs_id_i / uses_rt_id_i, in, 1 each: ID instruction actually reads rs / rt.
- reg_wr_ex_i, mem_to_reg_ex_i, in, 1 each: write-enable and load flag of the EX instruction.
- rd_ex_i, in, 5: destination register of the EX instruction.
- reg_wr_mem_i, in, 1: write-enable of the MEM instruction.
- rd_mem_i, in, 5: destination register of the MEM instruction.
- branch_taken_ex_i, in, 1: branch/jump in EX resolved taken.
- muldiv_start_ex_i, in, 1: mul/div instruction present in EX.
- stall_clr_i, in, 1: synchronous clear of the stall counter.
- pc_en_o, out, 1: PC update enable.
- if_id_en_o, out, 1: IF/ID register capture enable.
- if_id_flush_o, out, 1: IF/ID loads a NOP.
- id_ex_flush_o, out, 1: ID/EX loads a bubble (all control bits 0).
- ex_mem_bubble_o, out, 1: EX/MEM loads a bubble.
- muldiv_busy_o, out, 1: mul/div in progress.
- muldiv_done_o, out, 1: one-cycle pulse on the last mul/div cycle.
- stall_cycles_o, out, 16: saturating count of frozen-front-end cycles.
REQ-003 SHALL implement clock and reset exactly as above: one clock, reset synchronous and active-high.

Function
REQ-004 SHALL hold a 2-state FSM, RUN and MD_BUSY, plus a 6-bit countdown md_cnt.
REQ-005 RUN to MD_BUSY SHALL occur when muldiv_start_ex_i=1 and branch_taken_ex_i=0; md_cnt loads MULDIV_CYCLES-1.
REQ-006 In MD_BUSY, md_cnt SHALL decrement each cycle; at md_cnt=0 the FSM returns to RUN and muldiv_done_o=1 for that cycle only.
REQ-007 In MD_BUSY the block SHALL drive pc_en_o=0, if_id_en_o=0, id_ex_flush_o=0 (ID/EX held by its own enable path) and ex_mem_bubble_o=1; muldiv_busy_o=1.
REQ-008 In MD_BUSY, muldiv_start_ex_i SHALL be ignored, and so SHALL branch_taken_ex_i (EX holds the mul/div).
REQ-009 A RAW hazard SHALL exist when a used source (uses_x_id_i=1) equals a destination with write enable set and destination is not 0; register 0 never hazards.
REQ-010 In RUN with a hazard and no taken branch, outputs SHALL be pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; the hazard check is combinational and re-evaluated every cycle.
REQ-011 A taken branch in RUN SHALL win over any hazard: pc_en_o=1, if_id_flush_o=1, id_ex_flush_o=1, no stall, and no MD_BUSY entry.
REQ-012 With no event in RUN: pc_en_o=1, if_id_en_o=1, all flush/bubble outputs 0.
REQ-013 stall_cycles_o SHALL increment on every non-reset cycle with pc_en_o=0 and saturate at 0xFFFF; stall_clr_i=1 zeroes it and takes priority over increment.

Reset
REQ-014 While reset=1 the block SHALL set FSM=RUN, md_cnt=0 and stall_cycles_o=0 at the next edge.
REQ-015 While reset=1 the outputs SHALL be: pc_en_o=0, if_id_en_o=0, if_id_flush_o=1, id_ex_flush_o=1, ex_mem_bubble_o=1, muldiv_busy_o=0, muldiv_done_o=0.
REQ-016 Reset during MD_BUSY SHALL abort the operation with no muldiv_done_o pulse.

Configuration
REQ-017 Macro HAZ_FORWARD_EN defined: only load-use is a hazard (reg_wr_ex_i=1, mem_to_reg_ex_i=1, rd_ex_i matches); MEM-stage and non-load EX writers do not stall.
REQ-018 HAZ_FORWARD_EN undefined: any match against the EX writer (any type) or the MEM writer (reg_wr_mem_i=1, rd_mem_i) is a hazard; the register file is write-before-read, so no WB check is needed.

Verification
REQ-019 Load x5 in EX, ID uses rs=5, forwarding on -> exactly 1 cycle with pc_en_o=0 and id_ex_flush_o=1; stall_cycles_o becomes 1.
REQ-020 Forwarding off, ALU writer x7 in EX, ID reads rt=7 -> 2 stall cycles (EX then MEM), then pc_en_o=1.
REQ-021 Load x5 in EX, ID uses x5, branch_taken_ex_i=1 in the same cycle -> no stall; if_id_flush_o=1 and id_ex_flush_o=1.
REQ-022 muldiv_start_ex_i pulse with MULDIV_CYCLES=4 -> muldiv_busy_o=1 for 4 cycles, muldiv_done_o on the 4th, stall_cycles_o increases by 4.
REQ-023 Reset asserted in the 2nd MD_BUSY cycle -> next cycle in RUN, no done pulse, counter 0; writer to rd=0 never stalls.
REQ-024 Force 65540 stall cycles -> stall_cycles_o=0xFFFF; stall_clr_i together with a stall -> counter becomes 0.
